// File: rtl/vector_alu_sequencer_if.sv
// Operand, lane-ALU and writeback signals of the vector ALU sequencer.
// slave = the sequencer; master = issue/lane/writeback environment.
interface vector_alu_sequencer_if #(
    parameter int LONGEST_LEN      = 64,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3,
    parameter int LANE_INDEX_SIZE  = 1
);
    localparam int LANE_NUM = 1 << LANE_INDEX_SIZE;

    logic                              in_valid;
    logic                              in_ready;
    logic [ENTRY_INDEX_SIZE:0]         vl;
    logic [2:0]                        vsew;
    logic [5:0]                        opcode;
    logic                              vm;
    logic                              mask_as_operand;
    logic                              is_mask_operation;
    logic [VECTOR_SIZE-1:0]            v0_mask;
    logic [VECTOR_SIZE*LONGEST_LEN-1:0] vs1;
    logic [VECTOR_SIZE*LONGEST_LEN-1:0] vs2;
    logic [VECTOR_SIZE*LONGEST_LEN-1:0] vs3;

    logic [LANE_NUM*LONGEST_LEN-1:0]   lane_vs1;
    logic [LANE_NUM*LONGEST_LEN-1:0]   lane_vs2;
    logic [LANE_NUM*LONGEST_LEN-1:0]   lane_vs3;
    logic [LANE_NUM-1:0]               lane_mask;
    logic                              lane_vm;
    logic [2:0]                        lane_vsew;
    logic [5:0]                        lane_opcode;
    logic                              lane_is_mask_op;
    logic [LANE_NUM-1:0]               lane_active;
    logic [LANE_NUM*LONGEST_LEN-1:0]   lane_result;

    logic                              out_valid;
    logic                              out_ready;
    logic [VECTOR_SIZE*LONGEST_LEN-1:0] result;

    modport slave (
        input  in_valid, vl, vsew, opcode, vm, mask_as_operand, is_mask_operation,
               v0_mask, vs1, vs2, vs3, lane_result, out_ready,
        output in_ready, lane_vs1, lane_vs2, lane_vs3, lane_mask, lane_vm, lane_vsew,
               lane_opcode, lane_is_mask_op, lane_active, out_valid, result
    );

    modport master (
        output in_valid, vl, vsew, opcode, vm, mask_as_operand, is_mask_operation,
               v0_mask, vs1, vs2, vs3, lane_result, out_ready,
        input  in_ready, lane_vs1, lane_vs2, lane_vs3, lane_mask, lane_vm, lane_vsew,
               lane_opcode, lane_is_mask_op, lane_active, out_valid, result
    );
endinterface

// File: rtl/vector_alu_sequencer.sv
// Walks one vector instruction across LANE_NUM lane ALUs, one element group per cycle, merging into vd.
// Latency ceil(vl/LANE_NUM)+1 cycles; result held in DONE until out_ready, in_ready only in IDLE.
module vector_alu_sequencer #(
    parameter int LONGEST_LEN      = 64,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3,
    parameter int LANE_INDEX_SIZE  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    vector_alu_sequencer_if.slave bus
);
    localparam int LANE_NUM = 1 << LANE_INDEX_SIZE;
    localparam int EW       = ENTRY_INDEX_SIZE + 1;
    localparam int SW       = $clog2(LONGEST_LEN);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [EW-1:0] vl;
        logic [2:0]    vsew;
        logic [5:0]    opcode;
        logic          vm;
        logic          mask_as_operand;
        logic          is_mask_op;
    } cfg_t;

    typedef logic [VECTOR_SIZE-1:0][LONGEST_LEN-1:0] vreg_t;
    typedef logic [LANE_NUM-1:0][LONGEST_LEN-1:0]    lreg_t;

    state_t                      state_q, state_d;
    cfg_t                        cfg_q;
    logic [VECTOR_SIZE-1:0]      v0_q;
    vreg_t                       vs1_q, vs2_q, vs3_q, result_q;
    logic [EW-1:0]               g_q;

    logic                        accept, last_group;
    logic [EW-1:0]               vl_clamped, base, next_base;
    logic [ENTRY_INDEX_SIZE-1:0] ent [LANE_NUM];
    logic [LANE_NUM-1:0]         body, act, lane_mask_w;
    lreg_t                       lane_vs1_w, lane_vs2_w, lane_vs3_w, lane_res;

    assign bus.in_ready = (state_q == IDLE) && !rst;
    assign accept       = bus.in_valid && bus.in_ready;
    assign vl_clamped   = (bus.vl > EW'(VECTOR_SIZE)) ? EW'(VECTOR_SIZE) : bus.vl;
    assign base         = g_q << LANE_INDEX_SIZE;
    assign next_base    = base + EW'(LANE_NUM);
    assign last_group   = next_base >= cfg_q.vl;
    assign lane_res     = bus.lane_result;

    // body = element inside vl; act additionally honours the v0 mask unless v0 is a data operand
    always_comb begin
        for (int k = 0; k < LANE_NUM; k++) begin
            ent[k]  = ENTRY_INDEX_SIZE'(base + EW'(k));
            body[k] = (state_q == RUN) && ((base + EW'(k)) < cfg_q.vl);
            act[k]  = body[k] && (cfg_q.vm || cfg_q.mask_as_operand || v0_q[ent[k]]);
        end
    end

    always_comb begin
        lane_vs1_w  = '0;
        lane_vs2_w  = '0;
        lane_vs3_w  = '0;
        lane_mask_w = '0;
        if (state_q == RUN) begin
            for (int k = 0; k < LANE_NUM; k++) begin
                lane_vs1_w[k]  = vs1_q[ent[k]];
                lane_vs2_w[k]  = vs2_q[ent[k]];
                lane_vs3_w[k]  = vs3_q[ent[k]];
                lane_mask_w[k] = v0_q[ent[k]];
            end
        end
    end

    assign bus.lane_vs1        = lane_vs1_w;
    assign bus.lane_vs2        = lane_vs2_w;
    assign bus.lane_vs3        = lane_vs3_w;
    assign bus.lane_mask       = lane_mask_w;
    assign bus.lane_active     = body;
    // Masking is resolved here, so lanes run unmasked unless v0 feeds the op itself
    assign bus.lane_vm         = (state_q == RUN) &&
                                 (cfg_q.vm || (!cfg_q.mask_as_operand && (|act)));
    assign bus.lane_vsew       = (state_q == RUN) ? cfg_q.vsew   : '0;
    assign bus.lane_opcode     = (state_q == RUN) ? cfg_q.opcode : '0;
    assign bus.lane_is_mask_op = (state_q == RUN) && cfg_q.is_mask_op;
    assign bus.out_valid       = (state_q == DONE);
    assign bus.result          = result_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (vl_clamped == '0) ? DONE : RUN;
            RUN:     if (last_group) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q    <= '0;
            v0_q     <= '0;
            vs1_q    <= '0;
            vs2_q    <= '0;
            vs3_q    <= '0;
            result_q <= '0;
            g_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    cfg_q    <= '{vl: vl_clamped, vsew: bus.vsew, opcode: bus.opcode, vm: bus.vm,
                                  mask_as_operand: bus.mask_as_operand,
                                  is_mask_op: bus.is_mask_operation};
                    v0_q     <= bus.v0_mask;
                    vs1_q    <= bus.vs1;
                    vs2_q    <= bus.vs2;
                    vs3_q    <= bus.vs3;
                    result_q <= bus.vs3;
                    g_q      <= '0;
                end
                RUN: begin
                    for (int k = 0; k < LANE_NUM; k++) begin
                        if (act[k]) begin
                            if (cfg_q.is_mask_op) result_q[0][SW'(ent[k])] <= lane_res[k][0];
                            else                  result_q[ent[k]]         <= lane_res[k];
                        end
                    end
                    if (!last_group) g_q <= g_q + EW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Directed bench for vector_alu_sequencer with a behavioural lane ALU on the lane ports.
module tb_vector_alu_sequencer;
    localparam logic [5:0] OP_ADD    = 6'd0;
    localparam logic [5:0] OP_SUB    = 6'd2;
    localparam logic [5:0] OP_MADC   = 6'd17;
    localparam logic [2:0] SEW_FOUR  = 3'd2;
    localparam logic [2:0] SEW_EIGHT = 3'd3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vector_alu_sequencer_if #(.LONGEST_LEN(64), .VECTOR_SIZE(8), .ENTRY_INDEX_SIZE(3),
                              .LANE_INDEX_SIZE(1)) ifc ();

    vector_alu_sequencer #(.LONGEST_LEN(64), .VECTOR_SIZE(8), .ENTRY_INDEX_SIZE(3),
                           .LANE_INDEX_SIZE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0]       act_log [20];
    logic [127:0]     first_vs1;
    logic [1:0]       first_mask;
    logic             first_rdy;
    logic [7:0][63:0] v1, v2, v3, ex;
    logic [127:0]     lr;

    function automatic logic [63:0] alu(input logic [5:0] op, input logic [2:0] sew,
                                        input logic [63:0] a, input logic [63:0] b);
        logic [63:0] m;
        logic [64:0] s;
        int          w;
        w = 8 << sew[1:0];
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        s = {1'b0, a & m} + {1'b0, b & m};
        case (op)
            OP_ADD:  return (a + b) & m;
            OP_SUB:  return (a - b) & m;
            OP_MADC: return {63'd0, s[w]};
            default: return '0;
        endcase
    endfunction

    always_comb begin
        lr = '0;
        for (int k = 0; k < 2; k++)
            lr[k*64 +: 64] = alu(ifc.lane_opcode, ifc.lane_vsew,
                                 ifc.lane_vs2[k*64 +: 64], ifc.lane_vs1[k*64 +: 64]);
    end
    assign ifc.lane_result = lr;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run_op(input int groups, input string tag);
        int cyc;
        ifc.in_valid = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        first_vs1  = ifc.lane_vs1;
        first_mask = ifc.lane_mask;
        first_rdy  = ifc.in_ready;
        cyc = 0;
        while (!ifc.out_valid && cyc < 20) begin
            act_log[cyc] = ifc.lane_active;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, cyc, groups);
    endtask

    task automatic finish_op(input string tag);
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc.out_ready = 1'b0;
        check({tag, "_in_ready_after"}, ifc.in_ready, 1'b1);
        check({tag, "_out_valid_after"}, ifc.out_valid, 1'b0);
    endtask

    task automatic set_op(input logic [3:0] vl, input logic [5:0] op, input logic [2:0] sew,
                          input logic vm, input logic ismask, input logic [7:0] v0);
        ifc.vl = vl; ifc.opcode = op; ifc.vsew = sew; ifc.vm = vm;
        ifc.is_mask_operation = ismask; ifc.v0_mask = v0; ifc.mask_as_operand = 1'b0;
        ifc.vs1 = v1; ifc.vs2 = v2; ifc.vs3 = v3;
    endtask

    initial begin
        rst = 1'b1;
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
        v1 = '0; v2 = '0; v3 = '0;
        set_op(4'd0, OP_ADD, SEW_FOUR, 1'b1, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", ifc.in_ready, 1'b0);
        check("rst_out_valid", ifc.out_valid, 1'b0);
        check("rst_result", ifc.result, '0);
        check("rst_lane_active", ifc.lane_active, 2'b00);
        check("rst_lane_vs1", ifc.lane_vs1, '0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", ifc.in_ready, 1'b1);

        // vl=8 add: 4 groups, result 11*i
        for (int i = 0; i < 8; i++) begin v1[i] = 64'(i); v2[i] = 64'(10*i); v3[i] = '0; end
        set_op(4'd8, OP_ADD, SEW_FOUR, 1'b1, 1'b0, 8'h00);
        run_op(4, "add8");
        check("add8_in_ready_run", first_rdy, 1'b0);
        check("add8_lane_vs1_g0", first_vs1, {64'd1, 64'd0});
        check("add8_active_g0", act_log[0], 2'b11);
        for (int i = 0; i < 8; i++) ex[i] = 64'(11*i);
        check("add8_result", ifc.result, ex);
        finish_op("add8");

        // vl=5: tail keeps 0xAA, lane 1 idle in last group
        for (int i = 0; i < 8; i++) v3[i] = 64'hAA;
        set_op(4'd5, OP_ADD, SEW_FOUR, 1'b1, 1'b0, 8'h00);
        run_op(3, "add5");
        check("add5_active_g2", act_log[2], 2'b01);
        ex = {64'hAA, 64'hAA, 64'hAA, 64'd44, 64'd33, 64'd22, 64'd11, 64'd0};
        check("add5_result", ifc.result, ex);
        finish_op("add5");

        // masked sub, v0=1010_0101: elements 0,2,5,7 computed
        for (int i = 0; i < 8; i++) v3[i] = 64'hFF;
        set_op(4'd8, OP_SUB, SEW_FOUR, 1'b0, 1'b0, 8'b1010_0101);
        run_op(4, "sub");
        check("sub_lane_mask_g0", first_mask, 2'b01);
        ex = {64'd63, 64'hFF, 64'd45, 64'hFF, 64'hFF, 64'd18, 64'hFF, 64'd0};
        check("sub_result", ifc.result, ex);
        finish_op("sub");

        // madc mask result: carries 111110 in bits 0..5, bits 6..7 and other slots from vs3
        for (int i = 0; i < 8; i++) begin v1[i] = 64'(i); v2[i] = '1; v3[i] = 64'h5555; end
        v3[0] = 64'hFFFF_0000_0000_00C1;
        set_op(4'd6, OP_MADC, SEW_EIGHT, 1'b1, 1'b1, 8'h00);
        run_op(3, "madc");
        ex = v3;
        ex[0] = 64'hFFFF_0000_0000_00FE;
        check("madc_result", ifc.result, ex);
        finish_op("madc");

        // vl above VECTOR_SIZE clamps to 8
        for (int i = 0; i < 8; i++) begin v1[i] = 64'(i); v2[i] = 64'(10*i); v3[i] = 64'hAA; end
        set_op(4'd13, OP_ADD, SEW_FOUR, 1'b1, 1'b0, 8'h00);
        run_op(4, "clamp");
        for (int i = 0; i < 8; i++) ex[i] = 64'(11*i);
        check("clamp_result", ifc.result, ex);
        finish_op("clamp");

        // vl=0: immediate DONE, result = vs3, held under backpressure
        for (int i = 0; i < 8; i++) v3[i] = 64'(i) * 64'h1111;
        set_op(4'd0, OP_ADD, SEW_FOUR, 1'b1, 1'b0, 8'h00);
        run_op(0, "vl0");
        check("vl0_result", ifc.result, v3);
        set_op(4'd8, OP_ADD, SEW_FOUR, 1'b1, 1'b0, 8'h00);
        ifc.in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("vl0_hold_valid", ifc.out_valid, 1'b1);
            check("vl0_hold_result", ifc.result, v3);
            check("vl0_hold_in_ready", ifc.in_ready, 1'b0);
        end
        ifc.in_valid = 1'b0;
        finish_op("vl0");
        @(posedge clk); #1;
        check("vl0_not_queued", ifc.in_ready, 1'b1);
        check("vl0_idle_active", ifc.lane_active, 2'b00);

        // reset during RUN group 1, then a fresh instruction
        for (int i = 0; i < 8; i++) v3[i] = 64'hAA;
        set_op(4'd8, OP_ADD, SEW_FOUR, 1'b1, 1'b0, 8'h00);
        ifc.in_valid = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        check("rstrun_active_g0", ifc.lane_active, 2'b11);
        @(posedge clk); #1;
        check("rstrun_lane_vs1_g1", ifc.lane_vs1, {64'd3, 64'd2});
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstrun_out_valid", ifc.out_valid, 1'b0);
        check("rstrun_result", ifc.result, '0);
        check("rstrun_lane_active", ifc.lane_active, 2'b00);
        check("rstrun_in_ready", ifc.in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("rstrun_in_ready_after", ifc.in_ready, 1'b1);
        set_op(4'd3, OP_ADD, SEW_FOUR, 1'b1, 1'b0, 8'h00);
        run_op(2, "after_rst");
        ex = {64'hAA, 64'hAA, 64'hAA, 64'hAA, 64'hAA, 64'd22, 64'd11, 64'd0};
        check("after_rst_result", ifc.result, ex);
        finish_op("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vector_alu_sequencer.md
# vector_alu_sequencer

Sequences one vector arithmetic instruction across the per-lane vector ALUs. It accepts a whole-register operand set (vs1/vs2/vs3, v0 mask, vl, vsew, opcode) and drives LANE_NUM lane ALUs with one element group per cycle. It gathers the lane results into a destination register image, applying body/tail and mask-undisturbed merging. It sits between vector issue/register read and vector writeback, and owns the lane ALUs for the duration of an instruction.

## Interface
- LONGEST_LEN, 64, element slot width (one slot per element, ALU operand width)
- VECTOR_SIZE, 8, elements per vector register
- ENTRY_INDEX_SIZE, 3, log2(VECTOR_SIZE)
- LANE_INDEX_SIZE, 1, log2(LANE_NUM); LANE_NUM = 2^LANE_INDEX_SIZE; VECTOR_SIZE must be a multiple of LANE_NUM
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  high only in IDLE and not in reset
- vl  in  ENTRY_INDEX_SIZE+1  element count; values > VECTOR_SIZE clamp to VECTOR_SIZE
- vsew  in  3  element width code (ONE/TWO/FOUR/EIGHT_BYTE), passed to lanes
- opcode  in  6  vector ALU opcode, passed to lanes
- vm  in  1  1 = unmasked
- mask_as_operand  in  1  1 = v0 is a data operand (ADC/SBC); all body elements active
- is_mask_operation  in  1  result is one bit per element
- v0_mask  in  VECTOR_SIZE  mask bit per element
- vs1, vs2, vs3  in  VECTOR_SIZE*LONGEST_LEN  element i at [i*LONGEST_LEN +: LONGEST_LEN]; vs3 is the old vd
- lane_vs1, lane_vs2, lane_vs3  out  LANE_NUM*LONGEST_LEN  operands for lane k at slot k
- lane_mask  out  LANE_NUM  v0 bit of each lane's element
- lane_vm  out  1  latched vm, forced to 1 when mask_as_operand=0 and element active
- lane_vsew, lane_opcode, lane_is_mask_op  out  3/6/1  latched config
- lane_active  out  LANE_NUM  lane element is in body (index < vl)
- lane_result  in  LANE_NUM*LONGEST_LEN  combinational results from lane ALUs
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts
- result  out  VECTOR_SIZE*LONGEST_LEN  destination register image

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: when in_valid && in_ready, latch all inputs and set group counter g=0. Next state is RUN, or DONE if vl==0.
  - RUN: drive group g; element index e = g*LANE_NUM+k for lane k. Capture results at the clock edge. If (g+1)*LANE_NUM >= vl, go to DONE; else g++.
  - DONE: out_valid=1, result held stable. On out_ready go to IDLE.
- Element active: e < vl, and (vm || mask_as_operand || v0_mask[e]).
- Result merge, normal op: active element gets lane_result slot; masked-off or tail element keeps vs3 slot.
- Result merge, is_mask_operation: result = vs3, except bit e of slot 0 = lane_result[k*LONGEST_LEN] for active e. Masked-off and tail bits keep vs3.
- result is initialised to latched vs3 on accept, so vl==0 yields vs3.
- Lane outputs are zero in IDLE/DONE; lane_active=0 there.
- in_valid outside IDLE is ignored and not queued.
- The ALU zero-extends per vsew; the sequencer stores the full 64-bit slot unchanged.

## Timing
- Reset values: state IDLE, g=0, out_valid=0, result=0, all lane_* outputs 0, in_ready=0 while rst is high and 1 on the first cycle after.
- Accept at edge T puts RUN at T+1. Groups G = ceil(vl/LANE_NUM). out_valid rises at T+1+G (vl=0: T+1).
- Handshake at edge D (out_valid && out_ready) puts IDLE at D+1; in_ready=1 from D+1. No back-to-back accept in the same cycle as completion.
- Last partial group: lanes with e >= vl have lane_active=0 and their results are discarded.
- rst in any state: the next cycle is IDLE with reset values; partial result is discarded.
- out_ready is ignored outside DONE.

## Test plan
- LANE_NUM=2, vl=8, vm=1, VECTOR_ADD, FOUR_BYTE, vs1[i]=i, vs2[i]=10i, accept at T -> RUN T+1..T+4, out_valid at T+5, result[i]=11i.
- Same with vl=5, vs3[i]=0xAA -> 3 RUN cycles, lane1 inactive in group 2, result[0..4]=11i, result[5..7]=0xAA.
- vl=8, vm=0, v0_mask=8'b1010_0101, VECTOR_SUB, vs3=0xFF -> elements 0,2,5,7 = vs2-vs1, others 0xFF.
- VECTOR_MADC, is_mask_operation=1, vm=1, vl=6, EIGHT_BYTE, vs2[i]=all-ones, vs1[i]=i, vs3=0 -> result slot0 low bits = 6'b111110, bits 6..7 = vs3 bits, other slots = vs3.
- vl=0 -> out_valid at T+1, result=vs3. Hold out_ready=0 for 3 cycles -> result stable and in_valid ignored. Then out_ready=1 -> in_ready=1 next cycle.
- rst asserted during RUN group 1 -> next cycle IDLE, out_valid=0, result=0, lane_active=0. A new accept then completes normally.
